// File: rtl/addsub_pkg.sv
// addsub_pkg: segment-width derivation and parameter legality for the pipelined add/sub.
package addsub_pkg;
    function automatic int seg_width(input int width, input int stages);
        return stages >= 1 ? width / stages : 1;
    endfunction
    function automatic bit legal_cfg(input int width, input int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction
endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG-bit generate/propagate carry-lookahead adder segment.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);
    logic [SEG-1:0] g, p;
    logic [SEG:0] c;
    assign g = a & b;
    assign p = a ^ b;
    // each carry is expanded directly from g/p and ci rather than from its neighbour
    always_comb begin
        c = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            logic t;
            t = ci;
            for (int j = 0; j <= i; j++) t = g[j] | (p[j] & t);
            c[i+1] = t;
        end
    end
    assign s = p ^ c[SEG-1:0];
    assign co = c[SEG];
    assign c_msb_in = c[SEG-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep add/sub; stage s resolves carry segment s while upper operands
// and completed lower sum bits travel with the beat.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG = seg_width(WIDTH, STAGES);
    if (!legal_cfg(WIDTH, STAGES)) begin : g_bad
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end
    logic adv, ovf_r;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int LO = s * SEG;
        localparam int RW = WIDTH - LO;
        logic [RW-1:0] ai, bi;
        logic ci, si, vi, co, cm, cr, subr, vr;
        logic [SEG-1:0] so;
        logic [LO+SEG-1:0] sr, sr_d;
        // subtraction is folded into stage 0 as a + ~b + ~cin
        if (s == 0) begin : g_in
            assign ai = a;
            assign bi = b ^ {WIDTH{sub}};
            assign ci = cin ^ sub;
            assign si = sub;
            assign vi = in_valid;
            assign sr_d = so;
        end else begin : g_in
            assign ai = g_st[s-1].g_fwd.ar;
            assign bi = g_st[s-1].g_fwd.br;
            assign ci = g_st[s-1].cr;
            assign si = g_st[s-1].subr;
            assign vi = g_st[s-1].vr;
            assign sr_d = {so, g_st[s-1].sr};
        end
        addsub_seg #(.SEG(SEG)) u_seg (
            .a(ai[SEG-1:0]),
            .b(bi[SEG-1:0]),
            .ci(ci),
            .s(so),
            .co(co),
            .c_msb_in(cm)
        );
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vr <= 1'b0;
                sr <= '0;
                cr <= 1'b0;
                subr <= 1'b0;
            end else if (adv) begin
                vr <= vi;
                sr <= sr_d;
                cr <= co;
                subr <= si;
            end
        end
        if (s < STAGES - 1) begin : g_fwd
            logic [RW-SEG-1:0] ar, br;
            logic cm_unused;
            assign cm_unused = cm;
            always_ff @(posedge clk) begin
                if (adv) begin
                    ar <= ai[RW-1:SEG];
                    br <= bi[RW-1:SEG];
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (!rst_n) ovf_r <= 1'b0;
                else if (adv) ovf_r <= cm ^ co;
            end
        end
    end
    assign out_valid = g_st[STAGES-1].vr;
    assign sum = g_st[STAGES-1].sr;
    // raw carry is inverted on subtract so cout reads as borrow
    assign cout = g_st[STAGES-1].cr ^ g_st[STAGES-1].subr;
    assign ovf = ovf_r;
    assign zero = out_valid && sum == '0;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed table, stall/reset sequences and multi-config random regression.
module tb_pipelined_addsub;
    localparam int NBEAT = 10000;
    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [63:0] sum;
    } res_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    int tests = 0, fails = 0;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic in_ready, out_valid, cout, ovf, zero;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arithmetic reference: full-precision integer add/sub, then range checks
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic sb, input logic ci);
        res_t r;
        logic [65:0] m, ua, ub, u;
        logic signed [66:0] sx, sy, sv, lim;
        m = (66'd1 << w) - 66'd1;
        ua = {2'b0, x} & m;
        ub = {2'b0, y} & m;
        u = sb ? ua - ub - 66'(ci) : ua + ub + 66'(ci);
        r.sum = 64'(u & m);
        r.cout = sb ? (ua < ub + 66'(ci)) : u[w];
        sx = $signed({1'b0, ua});
        if (ua[w-1]) sx = sx - (67'sd1 <<< w);
        sy = $signed({1'b0, ub});
        if (ub[w-1]) sy = sy - (67'sd1 <<< w);
        sv = sb ? sx - sy : sx + sy;
        if (ci) sv = sb ? sv - 67'sd1 : sv + 67'sd1;
        lim = 67'sd1 <<< (w - 1);
        r.ovf = (sv >= lim) || (sv < -lim);
        r.zero = r.sum == 64'd0;
        return r;
    endfunction

    function automatic res_t cur_main();
        return {cout, ovf, zero, 32'h0, sum};
    endfunction

    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        a = v.a;
        b = v.b;
        sub = v.sub;
        cin = v.cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, 67'(lat), 67'(4));
        chk({nm, " result"}, cur_main(), {v.co, v.ov, v.z, 32'h0, v.s});
        tick();
    endtask

    for (genvar k = 0; k < 5; k++) begin : g_cfg
        localparam int W = k == 3 ? 64 : k == 4 ? 8 : 32;
        localparam int S = k == 0 ? 4 : k == 1 ? 1 : k == 2 ? 32 : k == 3 ? 8 : 2;
        logic rn = 1'b0, iv = 1'b0, ordy = 1'b0, sb = 1'b0, ci = 1'b0, fin = 1'b0;
        logic [W-1:0] ra = '0, rb = '0, rs;
        logic ir, ov, rc, ro, rz;
        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .sub(sb), .cin(ci), .out_valid(ov), .out_ready(ordy),
            .sum(rs), .cout(rc), .ovf(ro), .zero(rz)
        );
        function automatic logic [W-1:0] rnd();
            int unsigned r;
            r = $urandom_range(0, 7);
            return r == 0 ? {W{1'b1}} : r == 1 ? {W{1'b0}} : r == 2 ? {1'b0, {(W-1){1'b1}}} :
                   r == 3 ? {1'b1, {(W-1){1'b0}}} : W'({$urandom(), $urandom()});
        endfunction
        initial begin
            res_t q[$];
            res_t held, now;
            int sent = 0, cyc = 0;
            bit stalled = 1'b0;
            string tag;
            tag = $sformatf("cfg(%0d,%0d)", W, S);
            repeat (2) @(posedge clk);
            #1 rn = 1'b1;
            chk({tag, " reset out_valid"}, 67'(ov), 67'(0));
            while ((sent < NBEAT || q.size() != 0) && cyc < 40000) begin
                iv = sent < NBEAT && $urandom_range(0, 3) != 0;
                ra = rnd();
                rb = rnd();
                sb = 1'($urandom());
                ci = 1'($urandom());
                ordy = $urandom_range(0, 3) != 0;
                #1;
                now = {rc, ro, rz, 64'(rs)};
                chk({tag, " in_ready"}, 67'(ir), 67'(!ov || ordy));
                if (stalled) chk({tag, " hold"}, now, held);
                if (iv && ir) begin
                    q.push_back(model(W, 64'(ra), 64'(rb), sb, ci));
                    sent++;
                end
                if (ov && ordy) begin
                    chk({tag, " spurious beat"}, 67'(q.size() != 0), 67'(1));
                    if (q.size() != 0) chk({tag, " result"}, now, q.pop_front());
                end
                stalled = ov && !ordy;
                held = now;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk({tag, " all beats drained"}, 67'(sent == NBEAT && q.size() == 0), 67'(1));
            fin = 1'b1;
        end
    end

    initial begin
        vec_t tv[9];
        res_t ev[8];
        logic [31:0] sa[8], sbv[8];
        logic ss[8], sc[8];
        res_t held;
        int sent, rcv, t, stale, wt;
        tv[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
        tv[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tv[2] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        tv[3] = '{32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0};
        tv[4] = '{32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
        tv[5] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0};
        tv[6] = '{32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tv[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
        tv[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
        tick();
        tick();
        chk("reset out_valid", 67'(out_valid), 67'(0));
        chk("reset outputs", cur_main(), 67'(0));
        chk("reset in_ready", 67'(in_ready), 67'(1));
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tv[i]);

        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom();
            sbv[i] = $urandom();
            ss[i] = 1'($urandom());
            sc[i] = 1'($urandom());
            ev[i] = model(32, 64'(sa[i]), 64'(sbv[i]), ss[i], sc[i]);
        end
        sent = 0;
        rcv = 0;
        t = 0;
        held = '0;
        while (rcv < 8 && t < 60) begin
            in_valid = sent < 8;
            if (sent < 8) begin
                a = sa[sent];
                b = sbv[sent];
                sub = ss[sent];
                cin = sc[sent];
            end
            out_ready = !(t >= 5 && t <= 7);
            #1;
            if (!out_ready) begin
                chk($sformatf("stall t%0d in_ready", t), 67'(in_ready), 67'(0));
                chk($sformatf("stall t%0d out_valid", t), 67'(out_valid), 67'(1));
                if (t > 5) chk($sformatf("stall t%0d hold", t), cur_main(), held);
            end
            held = cur_main();
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("stream beat%0d", rcv), cur_main(), {ev[rcv].cout, ev[rcv].ovf, ev[rcv].zero, 32'h0, ev[rcv].sum[31:0]});
                rcv++;
            end
            tick();
            t++;
        end
        chk("stream beats out", 67'(rcv), 67'(8));
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 1);
            b = 32'h10;
            sub = 1'b0;
            cin = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midflight reset out_valid", 67'(out_valid), 67'(0));
        chk("midflight reset outputs", cur_main(), 67'(0));
        chk("midflight reset in_ready", 67'(in_ready), 67'(1));
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) stale++;
            tick();
        end
        chk("stale beats after reset", 67'(stale), 67'(0));
        run_vec("post-reset beat", '{32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0});

        wt = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin && g_cfg[4].fin) && wt < 60000) begin
            tick();
            wt++;
        end
        chk("regression finished", 67'(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin && g_cfg[4].fin), 67'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
